// File: rtl/sumador_pkg.sv
// Shared types, defaults and helpers for the pipelined CLA adder/subtractor.
package sumador_pkg;

    typedef enum logic {SUMA = 1'b0, RESTA = 1'b1} t_modo_suma;

    localparam int N_DEF      = 32;
    localparam int G_DEF      = 4;
    localparam int ETAPAS_DEF = 2;

    // Two's-complement overflow: same-sign operands giving a result of the other sign.
    function automatic logic desborde_f(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Flattened lookahead carry into position i from generate/propagate vectors:
    // c[i] = cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1]. Each term is an independent AND,
    // so the result is a sum of products rather than a ripple chain. Supports up to
    // 64 positions, well above any practical group or groups-per-slice count.
    function automatic logic carry_la(input logic [63:0] g, input logic [63:0] p,
                                      input logic cin, input int i);
        logic c;
        logic t;
        c = cin;
        for (int j = 0; j < i; j++) c = c & p[j];
        for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_bloque.sv
// G-bit carry-lookahead group: sum bits plus group generate/propagate for the
// lookahead unit one level up.
module cla_bloque
    import sumador_pkg::*;
#(
    parameter int G = 4
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic [G-1:0] s,
    output logic         gen,
    output logic         prop
);

    logic [G-1:0] w_g;
    logic [G-1:0] w_p;
    logic [G-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every bit carry is resolved directly from cin and the bit g/p terms.
    always_comb begin
        w_c = '0;
        for (int i = 0; i < G; i++) w_c[i] = carry_la(64'(w_g), 64'(w_p), cin, i);
    end

    assign s    = w_p ^ w_c;
    assign gen  = carry_la(64'(w_g), 64'(w_p), 1'b0, G);
    assign prop = &w_p;

endmodule

// File: rtl/sumador_cla_segmentado.sv
// Pipelined carry-lookahead adder/subtractor. Stage k resolves slice k of the
// operands; the slice carry, the finished low result bits and the still
// unprocessed high operand bits travel together down the pipe.
module sumador_cla_segmentado
    import sumador_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int G      = G_DEF,
    parameter int ETAPAS = ETAPAS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ValidoIn,
    output logic         ListoIn,
    input  logic [N-1:0] Operando1,
    input  logic [N-1:0] Operando2,
    input  logic         CarryIn,
    input  logic         Modo,
    output logic         ValidoOut,
    input  logic         ListoOut,
    output logic [N-1:0] Resultado,
    output logic         CarryOut,
    output logic         Desborde,
    output logic         Cero
);

    localparam int W  = N / ETAPAS;  // slice width per stage
    localparam int NG = W / G;       // lookahead groups per slice

    if ((ETAPAS < 1) || (N % (G * ETAPAS) != 0)) begin : g_chk_param
        $fatal(1, "sumador_cla_segmentado: N must be a multiple of G*ETAPAS, ETAPAS >= 1");
    end

    t_modo_suma   w_modo;
    logic [N-1:0] w_b_ef;
    logic         w_cin_ef;
    logic         w_avanza;

    // Subtraction is A + ~B + 1: invert B up front, force the incoming carry.
    assign w_modo   = t_modo_suma'(Modo);
    assign w_b_ef   = (w_modo == RESTA) ? ~Operando2 : Operando2;
    assign w_cin_ef = (w_modo == RESTA) ? 1'b1 : CarryIn;

    // Whole pipe moves in lockstep; it only freezes when the tail is full and blocked.
    assign w_avanza = !g_etapa[ETAPAS-1].r_v || ListoOut;
    assign ListoIn  = w_avanza;

    for (genvar k = 0; k < ETAPAS; k++) begin : g_etapa
        localparam int LO = k * W;

        logic [N-LO-1:0]    w_a_rest;
        logic [N-LO-1:0]    w_b_rest;
        logic [(k+1)*W-1:0] w_acc;
        logic               w_ci;
        logic               w_vin;
        logic [W-1:0]       w_a;
        logic [W-1:0]       w_b;
        logic [W-1:0]       w_s;
        logic [NG-1:0]      w_gg;
        logic [NG-1:0]      w_gp;
        logic [NG:0]        w_gc;
        logic               r_v;
        logic               r_c;
        logic [(k+1)*W-1:0] r_s;

        if (k == 0) begin : g_ent
            assign w_a_rest = Operando1;
            assign w_b_rest = w_b_ef;
            assign w_ci     = w_cin_ef;
            assign w_vin    = ValidoIn;
            assign w_acc    = w_s;
        end else begin : g_ent
            assign w_a_rest = g_etapa[k-1].g_fwd.r_a;
            assign w_b_rest = g_etapa[k-1].g_fwd.r_b;
            assign w_ci     = g_etapa[k-1].r_c;
            assign w_vin    = g_etapa[k-1].r_v;
            assign w_acc    = {w_s, g_etapa[k-1].r_s};
        end

        assign w_a = w_a_rest[W-1:0];
        assign w_b = w_b_rest[W-1:0];

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_bloque #(.G(G)) u_cla (
                .a    (w_a[j*G +: G]),
                .b    (w_b[j*G +: G]),
                .cin  (w_gc[j]),
                .s    (w_s[j*G +: G]),
                .gen  (w_gg[j]),
                .prop (w_gp[j])
            );
        end

        // Group-level lookahead: every group carry straight from the slice carry-in.
        always_comb begin
            w_gc = '0;
            for (int i = 0; i <= NG; i++) w_gc[i] = carry_la(64'(w_gg), 64'(w_gp), w_ci, i);
        end

        // Stage valid shifts every advance; data only loads with a real beat so
        // the outputs keep their last result across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_avanza) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_c <= w_gc[NG];
                    r_s <= w_acc;
                end
            end
        end

        if (k < ETAPAS - 1) begin : g_fwd
            logic [N-LO-W-1:0] r_a;
            logic [N-LO-W-1:0] r_b;

            // High operand bits not yet consumed ride along with the beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_avanza && w_vin) begin
                    r_a <= w_a_rest[N-LO-1:W];
                    r_b <= w_b_rest[N-LO-1:W];
                end
            end
        end else begin : g_fin
            logic r_desb;
            logic r_cero;

            // Flags need the full-width result, which only exists in the last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_desb <= 1'b0;
                    r_cero <= 1'b0;
                end else if (w_avanza && w_vin) begin
                    r_desb <= desborde_f(w_a[W-1], w_b[W-1], w_s[W-1]);
                    r_cero <= (w_acc == '0);
                end
            end
        end
    end

    assign ValidoOut = g_etapa[ETAPAS-1].r_v;
    assign Resultado = g_etapa[ETAPAS-1].r_s;
    assign CarryOut  = g_etapa[ETAPAS-1].r_c;
    assign Desborde  = g_etapa[ETAPAS-1].g_fin.r_desb;
    assign Cero      = g_etapa[ETAPAS-1].g_fin.r_cero;

endmodule

// File: tb/tb_sumador_cla_segmentado.sv
// Bench: directed scenarios on a 32-bit, 2-stage instance plus randomised
// 8-bit instances (1 and 2 stages) checked against an arithmetic model.
module tb_sumador_cla_segmentado;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       desb;
        logic       cero;
    } t_esp8;

    logic clk;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Arithmetic reference: plain integer sums and signed range checks.
    function automatic t_esp8 ref8(input logic [7:0] a, input logic [7:0] b,
                                   input logic m, input logic c);
        t_esp8 r;
        int ua, ub, sa, sb, su, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (m) begin
            su = ua - ub;
            ss = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            su = ua + ub + int'(c);
            ss = sa + sb + int'(c);
            r.cout = (su > 255);
        end
        r.res  = 8'(su);
        r.desb = (ss > 127) || (ss < -128);
        r.cero = (r.res == 8'h00);
        return r;
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- 32-bit, 2-stage instance (directed) ----------------
    logic        rst_n;
    logic        v32, li32, vo32, lo32, cin32, modo32, cout32, desb32, cero32;
    logic [31:0] a32, b32, res32;

    sumador_cla_segmentado #(.N(32), .G(4), .ETAPAS(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .ValidoIn(v32), .ListoIn(li32),
        .Operando1(a32), .Operando2(b32), .CarryIn(cin32), .Modo(modo32),
        .ValidoOut(vo32), .ListoOut(lo32), .Resultado(res32),
        .CarryOut(cout32), .Desborde(desb32), .Cero(cero32)
    );

    task automatic beat32(input logic [31:0] a, input logic [31:0] b, input logic m, input logic c);
        v32 = 1'b1; a32 = a; b32 = b; modo32 = m; cin32 = c;
    endtask

    // ---------------- 8-bit instances, randomised against the model ----------------
    for (genvar e = 1; e <= 2; e++) begin : g_r8
        localparam int E    = e;
        localparam int NCYC = 3000;

        logic       rst_l, v_in, l_in, v_out, l_out, cin, modo, cout, desb, cero;
        logic [7:0] a, b, res;
        logic       mv [E];
        t_esp8      ms [E];
        t_esp8      hold;
        logic       av, pend;
        bit         done = 1'b0;

        sumador_cla_segmentado #(.N(8), .G(4), .ETAPAS(E)) u_dut8 (
            .clk(clk), .rst_n(rst_l), .ValidoIn(v_in), .ListoIn(l_in),
            .Operando1(a), .Operando2(b), .CarryIn(cin), .Modo(modo),
            .ValidoOut(v_out), .ListoOut(l_out), .Resultado(res),
            .CarryOut(cout), .Desborde(desb), .Cero(cero)
        );

        initial begin
            rst_l = 1'b0; v_in = 1'b0; l_out = 1'b1; a = '0; b = '0; cin = 1'b0; modo = 1'b0;
            pend = 1'b0; hold = '0;
            for (int k = 0; k < E; k++) begin mv[k] = 1'b0; ms[k] = '0; end
            repeat (2) @(negedge clk);
            rst_l = 1'b1;
            for (int c = 0; c < NCYC; c++) begin
                @(negedge clk);
                if (c == 1502) rst_l = 1'b1;
                if (!pend) begin
                    v_in = ($urandom_range(0, 3) != 0);
                    a    = pick8();
                    b    = pick8();
                    modo = 1'($urandom);
                    cin  = 1'($urandom);
                end
                l_out = ($urandom_range(0, 3) != 0);
                #1;
                av = !mv[E-1] || l_out;
                chk($sformatf("r8_e%0d_c%0d", E, c),
                    64'({v_out, l_in, res, cout, desb, cero}), 64'({mv[E-1], av, hold}));
                pend = v_in && !av;
                if (rst_l && av) begin
                    for (int k = E - 1; k > 0; k--) begin mv[k] = mv[k-1]; ms[k] = ms[k-1]; end
                    mv[0] = v_in;
                    ms[0] = ref8(a, b, modo, cin);
                    if (mv[E-1]) hold = ms[E-1];
                end
                if (c == 1500) begin
                    #2 rst_l = 1'b0;
                    for (int k = 0; k < E; k++) mv[k] = 1'b0;
                    hold = '0;
                    pend = 1'b0;
                end
            end
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; lo32 = 1'b1;
        beat32(32'h0000_1234, 32'h1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vld",   64'(vo32), 64'(0));
        chk("rst_res",   64'(res32), 64'(0));
        chk("rst_flags", 64'({cout32, desb32, cero32}), 64'(0));
        chk("rst_listo", 64'(li32), 64'(1));
        @(negedge clk);
        v32 = 1'b0; rst_n = 1'b1;
        #1 chk("post_rst_listo", 64'(li32), 64'(1));

        // Wrap to zero with carry out.
        @(negedge clk) beat32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk) v32 = 1'b0;
        #1 chk("suma_lat", 64'(vo32), 64'(0));
        @(negedge clk); #1;
        chk("suma_wrap", 64'({vo32, res32, cout32, desb32, cero32}),
            64'({1'b1, 32'h0, 1'b1, 1'b0, 1'b1}));

        // Subtract across the sign boundary, then a borrowing subtract with CarryIn ignored.
        @(negedge clk) beat32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        @(negedge clk) v32 = 1'b0;
        @(negedge clk); #1;
        chk("resta_ovf", 64'({vo32, res32, cout32, desb32, cero32}),
            64'({1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}));
        @(negedge clk) beat32(32'd5, 32'd7, 1'b1, 1'b1);
        @(negedge clk) v32 = 1'b0;
        @(negedge clk); #1;
        chk("resta_borrow", 64'({vo32, res32, cout32, desb32, cero32}),
            64'({1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}));

        // Back-to-back beats with a 3-cycle downstream stall.
        @(negedge clk) beat32(32'd1, 32'd1, 1'b0, 1'b0);
        @(negedge clk) beat32(32'd2, 32'd2, 1'b0, 1'b0);
        @(negedge clk) beat32(32'd3, 32'd3, 1'b0, 1'b0);
        lo32 = 1'b0;
        #1 chk("stall_0", 64'({vo32, li32, res32}), 64'({1'b1, 1'b0, 32'd2}));
        @(negedge clk); #1 chk("stall_1", 64'({vo32, li32, res32}), 64'({1'b1, 1'b0, 32'd2}));
        @(negedge clk); #1 chk("stall_2", 64'({vo32, li32, res32}), 64'({1'b1, 1'b0, 32'd2}));
        @(negedge clk) lo32 = 1'b1;
        #1 chk("stall_rel", 64'({vo32, li32, res32}), 64'({1'b1, 1'b1, 32'd2}));
        @(negedge clk) v32 = 1'b0;
        #1 chk("orden_4", 64'({vo32, res32}), 64'({1'b1, 32'd4}));
        @(negedge clk); #1 chk("orden_6", 64'({vo32, res32}), 64'({1'b1, 32'd6}));
        @(negedge clk); #1 chk("vacio", 64'({vo32, res32}), 64'({1'b0, 32'd6}));

        // Asynchronous reset with two beats in flight.
        @(negedge clk) beat32(32'd10, 32'd20, 1'b0, 1'b0);
        @(negedge clk) beat32(32'd30, 32'd40, 1'b0, 1'b0);
        @(negedge clk) begin v32 = 1'b0; lo32 = 1'b0; end
        #1 chk("vuelo", 64'({vo32, res32}), 64'({1'b1, 32'd30}));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({vo32, res32, cout32, desb32, cero32}), 64'(0));
        @(negedge clk) begin rst_n = 1'b1; lo32 = 1'b1; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1 chk($sformatf("sin_rancio_%0d", i), 64'(vo32), 64'(0));
        end

        // Let the randomised instances finish, with a bounded wait.
        for (int i = 0; i < 20000 && !(g_r8[1].done && g_r8[2].done); i++) @(negedge clk);
        chk("r8_terminado", 64'(g_r8[1].done && g_r8[2].done), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
